// File: rtl/ripple_adder_ctrl_if.sv
// ---------------------------------------------------------------------------
// ripple_adder_ctrl_if
// Operand/result handshake bundle shared by the controller and its environment.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface ripple_adder_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_wrap;
  logic             busy;

  modport slave (
    input  in_valid, in_a, in_b, add_sum, out_ready,
    output in_ready, add_a, add_b, out_valid, out_sum, out_wrap, busy
  );

  modport master (
    output in_valid, in_a, in_b, add_sum, out_ready,
    input  in_ready, add_a, add_b, out_valid, out_sum, out_wrap, busy
  );
endinterface

`default_nettype wire

// File: rtl/ripple_adder_ctrl.sv
// ---------------------------------------------------------------------------
// ripple_adder_ctrl
// Registers operands for an external ripple adder, waits SETTLE cycles, then
// captures the sum and unsigned-overflow flag behind a valid/ready handshake.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ripple_adder_ctrl #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input wire logic               clk,
  input wire logic               rst_n,
  ripple_adder_ctrl_if.slave     bus
);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_settle = 2'd1;
  localparam logic [1:0] c_hold   = 2'd2;

  // SETTLE is limited to 1..15 so the load value always fits the 4-bit counter.
  localparam logic [3:0] c_cnt_load = 4'(SETTLE - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;

  logic [WIDTH-1:0] r_add_a;
  logic [WIDTH-1:0] r_add_b;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_wrap;
  logic             r_out_valid;

  logic             w_in_ready;
  logic             w_busy;
  logic             w_accept;
  logic             w_done;
  logic             w_release;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_idle: begin
        if (bus.in_valid) begin
          w_state_nxt = c_settle;
          w_cnt_nxt   = c_cnt_load;
        end
      end
      c_settle: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = c_hold;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      c_hold: begin
        if (bus.out_ready) begin
          w_state_nxt = c_idle;
        end
      end
      default: begin
        w_state_nxt = c_idle;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_comb begin
    w_in_ready = (r_state == c_idle);
    w_busy     = (r_state != c_idle);
    w_accept   = w_in_ready & bus.in_valid;
    w_done     = (r_state == c_settle) & (r_cnt == 4'd0);
    w_release  = (r_state == c_hold) & bus.out_ready;
  end

  // Overflow of an unsigned add shows up as a sum smaller than either operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_out_sum   <= '0;
      r_out_wrap  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_add_a <= bus.in_a;
        r_add_b <= bus.in_b;
      end
      if (w_done) begin
        r_out_sum   <= bus.add_sum;
        r_out_wrap  <= (bus.add_sum < r_add_a);
        r_out_valid <= 1'b1;
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.busy      = w_busy;
  assign bus.add_a     = r_add_a;
  assign bus.add_b     = r_add_b;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_wrap  = r_out_wrap;
  assign bus.out_valid = r_out_valid;

endmodule

`default_nettype wire
